barrel_shifter_pipe: RTL and testbench

- Operand shifter stage directly downstream of the shift-amount/shift-type generator in the ARM7 execute path.
- Consumes BS_Shift_Amt / BS_Shift_Type plus the operand, and produces the shifted operand and shifter carry-out for the ALU.
- Implements ARM LSL/LSR/ASR/ROR, including the immediate-encoding special cases (LSR #0, ASR #0, RRX).
- Pipelined, with a valid/stall/flush handshake.

---
 rtl/barrel_shifter_pipe.sv | 106 ++++++++++
 tb/tb_barrel_shifter_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined ARM LSL/LSR/ASR/ROR operand shifter with valid/stall/flush handshake
// Define BS_ZERO_FLAG_EN to add the registered BS_Out_Zero output.
module barrel_shifter_pipe #(
    parameter int PIPE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        BS_In_Valid,
    input  logic        BS_Stall,
    input  logic        BS_Flush,
    input  logic [31:0] BS_Operand,
    input  logic [4:0]  BS_Shift_Amt,
    input  logic [1:0]  BS_Shift_Type,
    input  logic        BS_Imm_Shift,
    input  logic        BS_Carry_In,
`ifdef BS_ZERO_FLAG_EN
    output logic        BS_Out_Zero,
`endif
    output logic        BS_Out_Valid,
    output logic [31:0] BS_Out,
    output logic        BS_Carry_Out
);
    localparam logic [1:0] LSL = 2'd0, LSR = 2'd1, ASR = 2'd2, ROR = 2'd3;

    function automatic logic [31:0] shf(input logic [31:0] x, input logic [1:0] t, input logic [4:0] a);
        logic [31:0] asr;
        asr = $signed(x) >>> a;
        shf = t == LSL ? x << a : t == LSR ? x >> a : t == ASR ? asr : (x >> a) | (x << (6'd32 - {1'b0, a}));
    endfunction

    logic        sp, sp_cy, cy0;
    logic [31:0] sp_out;
    logic [4:0]  li, ri;

    // amt==0 is always resolved here; only immediate encodings change the result
    always_comb begin
        sp = BS_Shift_Amt == 5'd0;
        li = 5'd0 - BS_Shift_Amt;
        ri = BS_Shift_Amt - 5'd1;
        sp_out = !BS_Imm_Shift || BS_Shift_Type == LSL ? BS_Operand :
                 BS_Shift_Type == LSR ? 32'd0 :
                 BS_Shift_Type == ASR ? {32{BS_Operand[31]}} : {BS_Carry_In, BS_Operand[31:1]};
        sp_cy = !BS_Imm_Shift || BS_Shift_Type == LSL ? BS_Carry_In :
                BS_Shift_Type == ROR ? BS_Operand[0] : BS_Operand[31];
        cy0 = sp ? sp_cy : BS_Operand[BS_Shift_Type == LSL ? li : ri];
    end

    logic [31:0] nxt_d;
    logic        nxt_cy, nxt_v;

    generate
        if (PIPE_DEPTH == 1) begin : g_one
            assign nxt_d  = sp ? sp_out : shf(BS_Operand, BS_Shift_Type, BS_Shift_Amt);
            assign nxt_cy = cy0;
            assign nxt_v  = BS_In_Valid;
        end else begin : g_two
            logic        s0_v, s0_cy;
            logic [31:0] s0_d;
            logic [1:0]  s0_t, s0_f;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    s0_v  <= 1'b0;
                    s0_cy <= 1'b0;
                    s0_d  <= 32'd0;
                    s0_t  <= 2'd0;
                    s0_f  <= 2'd0;
                end else begin
                    if (!BS_Stall) begin
                        s0_v  <= BS_In_Valid;
                        s0_cy <= cy0;
                        s0_d  <= sp ? sp_out : shf(BS_Operand, BS_Shift_Type, {BS_Shift_Amt[4:2], 2'b00});
                        s0_t  <= BS_Shift_Type;
                        s0_f  <= sp ? 2'd0 : BS_Shift_Amt[1:0];
                    end
                    if (BS_Flush) s0_v <= 1'b0;
                end
            end
            // coarse and fine shifts of the same kind compose exactly, rotate included
            assign nxt_d  = shf(s0_d, s0_t, {3'b000, s0_f});
            assign nxt_cy = s0_cy;
            assign nxt_v  = s0_v;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            BS_Out_Valid <= 1'b0;
            BS_Out       <= 32'd0;
            BS_Carry_Out <= 1'b0;
        end else begin
            if (!BS_Stall) begin
                BS_Out_Valid <= nxt_v;
                BS_Out       <= nxt_d;
                BS_Carry_Out <= nxt_cy;
            end
            if (BS_Flush) BS_Out_Valid <= 1'b0;
        end
    end

`ifdef BS_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (!reset_n) BS_Out_Zero <= 1'b0;
        else if (!BS_Stall) BS_Out_Zero <= nxt_d == 32'd0;
    end
`endif
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: scoreboard bench for barrel_shifter_pipe
// Checks BS_Out_Zero as well when BS_ZERO_FLAG_EN is defined.
module tb_barrel_shifter_pipe;
    localparam int PD = 2;

    typedef struct packed {
        logic [31:0] x;
        logic [4:0]  a;
        logic [1:0]  t;
        logic        imm;
        logic        c;
    } vec_t;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        BS_In_Valid = 1'b0, BS_Stall = 1'b0, BS_Flush = 1'b0;
    logic [31:0] BS_Operand = '0;
    logic [4:0]  BS_Shift_Amt = '0;
    logic [1:0]  BS_Shift_Type = '0;
    logic        BS_Imm_Shift = 1'b0, BS_Carry_In = 1'b0;
    logic        BS_Out_Valid, BS_Carry_Out;
    logic [31:0] BS_Out;
`ifdef BS_ZERO_FLAG_EN
    logic        BS_Out_Zero;
`endif

    int checks = 0, failures = 0;
    logic [32:0] exp_q[$];
    logic [32:0] e;

    always #5 clk = ~clk;

    barrel_shifter_pipe #(.PIPE_DEPTH(PD)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .BS_In_Valid(BS_In_Valid),
        .BS_Stall(BS_Stall),
        .BS_Flush(BS_Flush),
        .BS_Operand(BS_Operand),
        .BS_Shift_Amt(BS_Shift_Amt),
        .BS_Shift_Type(BS_Shift_Type),
        .BS_Imm_Shift(BS_Imm_Shift),
        .BS_Carry_In(BS_Carry_In),
`ifdef BS_ZERO_FLAG_EN
        .BS_Out_Zero(BS_Out_Zero),
`endif
        .BS_Out_Valid(BS_Out_Valid),
        .BS_Out(BS_Out),
        .BS_Carry_Out(BS_Carry_Out)
    );

    // bit-serial reference: one single-bit step per unit of shift amount
    function automatic logic [32:0] model(input logic [31:0] x, input logic [4:0] a, input logic [1:0] t,
                                          input logic imm, input logic c);
        logic [31:0] r;
        logic cy;
        r = x;
        cy = c;
        if (a == 5'd0) begin
            if (imm && t == 2'd1) begin r = 32'd0; cy = x[31]; end
            else if (imm && t == 2'd2) begin r = {32{x[31]}}; cy = x[31]; end
            else if (imm && t == 2'd3) begin r = {c, x[31:1]}; cy = x[0]; end
        end else begin
            for (int i = 0; i < int'(a); i++) begin
                if (t == 2'd0) begin cy = r[31]; r = r << 1; end
                else begin cy = r[0]; r = {t == 2'd2 ? r[31] : t == 2'd3 ? r[0] : 1'b0, r[31:1]}; end
            end
        end
        return {cy, r};
    endfunction

    task automatic drive(input logic [31:0] x, input logic [4:0] a, input logic [1:0] t,
                         input logic imm, input logic c, input logic v);
        BS_Operand = x;
        BS_Shift_Amt = a;
        BS_Shift_Type = t;
        BS_Imm_Shift = imm;
        BS_Carry_In = c;
        BS_In_Valid = v;
        if (v && !BS_Stall && !BS_Flush && reset_n) exp_q.push_back(model(x, a, t, imm, c));
    endtask

    task automatic idle();
        drive($urandom, 5'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        checks += 3;
        if (BS_Out_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", BS_Out_Valid); end
        if (BS_Out !== 32'd0) begin failures++; $display("FAIL reset_out got %h exp 0", BS_Out); end
        if (BS_Carry_Out !== 1'b0) begin failures++; $display("FAIL reset_carry got %b exp 0", BS_Carry_Out); end
`ifdef BS_ZERO_FLAG_EN
        checks++;
        if (BS_Out_Zero !== 1'b0) begin failures++; $display("FAIL reset_zero got %b exp 0", BS_Out_Zero); end
`endif
        reset_n = 1'b1;
    endtask

    task automatic test_lsl_latency();
        int lat = 0;
        @(negedge clk);
        drive(32'h80000001, 5'd1, 2'd0, 1'b1, 1'b0, 1'b1);
        do begin
            @(negedge clk);
            idle();
            lat++;
        end while (!BS_Out_Valid && lat < 8);
        checks++;
        if (lat != PD) begin failures++; $display("FAIL lsl_latency got %0d exp %0d", lat, PD); end
        checks++;
        e = exp_q.size() ? exp_q.pop_front() : 33'h0;
        if (!BS_Out_Valid || {BS_Carry_Out, BS_Out} !== e || e !== {1'b1, 32'h2}) begin
            failures++;
            $display("FAIL lsl_result got v=%b cy=%b out=%h exp cy=1 out=00000002", BS_Out_Valid, BS_Carry_Out, BS_Out);
        end
    endtask

    task automatic test_directed();
        vec_t v[9] = '{
            '{32'h80000000, 5'd0, 2'd1, 1'b1, 1'b0},
            '{32'h80000000, 5'd0, 2'd2, 1'b1, 1'b0},
            '{32'h00000001, 5'd0, 2'd3, 1'b1, 1'b1},
            '{32'h000000FF, 5'd8, 2'd3, 1'b0, 1'b0},
            '{32'h000000FF, 5'd0, 2'd3, 1'b0, 1'b0},
            '{32'hF0000000, 5'd4, 2'd2, 1'b0, 1'b0},
            '{32'hF0000000, 5'd0, 2'd1, 1'b0, 1'b1},
            '{32'h00000001, 5'd1, 2'd1, 1'b0, 1'b0},
            '{32'h00000003, 5'd31, 2'd0, 1'b0, 1'b0}};
        for (int i = 0; i < 9 + PD + 3; i++) begin
            @(negedge clk);
            if (BS_Out_Valid) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL directed_extra got out=%h", BS_Out); end
                else begin
                    e = exp_q.pop_front();
                    if ({BS_Carry_Out, BS_Out} !== e) begin
                        failures++;
                        $display("FAIL directed got cy=%b out=%h exp cy=%b out=%h", BS_Carry_Out, BS_Out, e[32], e[31:0]);
                    end
`ifdef BS_ZERO_FLAG_EN
                    checks++;
                    if (BS_Out_Zero !== (e[31:0] == 32'd0)) begin failures++; $display("FAIL directed_zero got %b exp %b", BS_Out_Zero, e[31:0] == 32'd0); end
`endif
                end
            end
            if (i < 9) drive(v[i].x, v[i].a, v[i].t, v[i].imm, v[i].c, 1'b1);
            else idle();
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL directed_missing got %0d left exp 0", exp_q.size()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 100 + PD + 3; i++) begin
            @(negedge clk);
            if (BS_Out_Valid) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL random_extra got out=%h", BS_Out); end
                else begin
                    e = exp_q.pop_front();
                    if ({BS_Carry_Out, BS_Out} !== e) begin
                        failures++;
                        $display("FAIL random got cy=%b out=%h exp cy=%b out=%h", BS_Carry_Out, BS_Out, e[32], e[31:0]);
                    end
`ifdef BS_ZERO_FLAG_EN
                    checks++;
                    if (BS_Out_Zero !== (e[31:0] == 32'd0)) begin failures++; $display("FAIL random_zero got %b exp %b", BS_Out_Zero, e[31:0] == 32'd0); end
`endif
                end
            end
            if (i < 100)
                drive($urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 1)) : $urandom,
                      $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom), 2'($urandom),
                      1'($urandom), 1'($urandom), $urandom_range(0, 4) != 0);
            else idle();
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL random_missing got %0d left exp 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        vec_t v[4] = '{
            '{32'h12345678, 5'd4, 2'd0, 1'b0, 1'b0},
            '{32'h87654321, 5'd7, 2'd2, 1'b0, 1'b1},
            '{32'hA5A5A5A5, 5'd13, 2'd3, 1'b0, 1'b0},
            '{32'h0000F00F, 5'd0, 2'd3, 1'b1, 1'b1}};
        logic [32:0] snap = '0;
        logic snap_v = 1'b0;
        int got = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (BS_Stall) begin
                checks++;
                if ({BS_Out_Valid, BS_Carry_Out, BS_Out} !== {snap_v, snap}) begin
                    failures++;
                    $display("FAIL stall_hold got v=%b cy=%b out=%h exp v=%b cy=%b out=%h",
                             BS_Out_Valid, BS_Carry_Out, BS_Out, snap_v, snap[32], snap[31:0]);
                end
            end else begin
                if (BS_Out_Valid) begin
                    checks++;
                    got++;
                    if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_extra got out=%h", BS_Out); end
                    else begin
                        e = exp_q.pop_front();
                        if ({BS_Carry_Out, BS_Out} !== e) begin
                            failures++;
                            $display("FAIL b2b got cy=%b out=%h exp cy=%b out=%h", BS_Carry_Out, BS_Out, e[32], e[31:0]);
                        end
                    end
                end
                snap = {BS_Carry_Out, BS_Out};
                snap_v = BS_Out_Valid;
            end
            if (i == 2 || i == 3) BS_Stall = 1'b1;
            else BS_Stall = 1'b0;
            if (i == 0) drive(v[0].x, v[0].a, v[0].t, v[0].imm, v[0].c, 1'b1);
            else if (i == 1) drive(v[1].x, v[1].a, v[1].t, v[1].imm, v[1].c, 1'b1);
            else if (i >= 2 && i <= 4) drive(v[2].x, v[2].a, v[2].t, v[2].imm, v[2].c, 1'b1);
            else if (i == 5) drive(v[3].x, v[3].a, v[3].t, v[3].imm, v[3].c, 1'b1);
            else idle();
        end
        checks += 2;
        if (got != 4) begin failures++; $display("FAIL b2b_count got %0d exp 4", got); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_missing got %0d left exp 0", exp_q.size()); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                checks++;
                if (BS_Out_Valid !== 1'b0) begin failures++; $display("FAIL flush_valid cycle %0d got %b exp 0", i, BS_Out_Valid); end
                if (i == 3) exp_q.delete();
            end else if (BS_Out_Valid) begin
                checks++;
                e = exp_q.size() ? exp_q.pop_front() : 33'h0;
                if ({BS_Carry_Out, BS_Out} !== e) begin
                    failures++;
                    $display("FAIL flush_pre got cy=%b out=%h exp cy=%b out=%h", BS_Carry_Out, BS_Out, e[32], e[31:0]);
                end
            end
            BS_Stall = i == 2;
            BS_Flush = i == 2;
            if (i == 0) drive(32'h0000_00F0, 5'd4, 2'd1, 1'b0, 1'b0, 1'b1);
            else if (i == 1) drive(32'hFFFF_0000, 5'd8, 2'd0, 1'b0, 1'b1, 1'b1);
            else if (i == 2) drive(32'h1111_1111, 5'd1, 2'd3, 1'b0, 1'b0, 1'b1);
            else idle();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 3) begin
                checks += 3;
                if (BS_Out_Valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got %b exp 0", BS_Out_Valid); end
                if (BS_Out !== 32'd0) begin failures++; $display("FAIL rst_mid_out got %h exp 0", BS_Out); end
                if (BS_Carry_Out !== 1'b0) begin failures++; $display("FAIL rst_mid_carry got %b exp 0", BS_Carry_Out); end
`ifdef BS_ZERO_FLAG_EN
                checks++;
                if (BS_Out_Zero !== 1'b0) begin failures++; $display("FAIL rst_mid_zero got %b exp 0", BS_Out_Zero); end
`endif
                exp_q.delete();
                reset_n = 1'b1;
                BS_Stall = 1'b0;
            end else if (i > 3) begin
                checks++;
                if (BS_Out_Valid !== 1'b0) begin failures++; $display("FAIL rst_mid_after got %b exp 0", BS_Out_Valid); end
            end else if (BS_Out_Valid) begin
                checks++;
                e = exp_q.size() ? exp_q.pop_front() : 33'h0;
                if ({BS_Carry_Out, BS_Out} !== e) begin
                    failures++;
                    $display("FAIL rst_mid_pre got cy=%b out=%h exp cy=%b out=%h", BS_Carry_Out, BS_Out, e[32], e[31:0]);
                end
            end
            if (i == 0) drive(32'hDEAD_BEEF, 5'd3, 2'd3, 1'b0, 1'b1, 1'b1);
            else if (i == 1) drive(32'h8000_0001, 5'd2, 2'd2, 1'b0, 1'b0, 1'b1);
            else if (i == 2) begin
                reset_n = 1'b0;
                BS_Stall = 1'b1;
                idle();
            end else idle();
        end
    endtask

    initial begin
        test_reset();
        test_lsl_latency();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
